// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches over a req/ack handshake and issues over valid/ready.
// Optional performance counters are enabled with `define IFU_PERF_CNT_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr,
    output logic [5:0]  o_opcode,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    input  logic        i_branch,
    input  logic        i_branch_taken,
    input  logic        i_jmp,
    input  logic        i_jr,
    input  logic [31:0] i_jr_target,
    output logic        o_addr_err
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] o_fetch_cnt,
    output logic [31:0] o_stall_cnt
`endif
);

    // state | meaning
    // FETCH | request outstanding at pc, waiting for imem_ack
    // ISSUE | instruction held for downstream, waiting for instr_ready
    // ERR   | redirect produced a misaligned pc; parked until reset
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_ISSUE = 2'd1,
        S_ERR   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_addr_err;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_next_pc;
    logic        w_accept;
    logic        w_fill;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign w_accept   = (r_state == S_ISSUE) && i_instr_ready;
    assign w_fill     = (r_state == S_FETCH) && i_imem_ack;

    // jr beats jmp beats taken branch; a jmp+branch combination silently resolves to jmp
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (i_jr) begin
            w_next_pc = i_jr_target;
        end else if (i_jmp) begin
            w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
        end else if (i_branch && i_branch_taken) begin
            w_next_pc = w_pc_plus4 + w_br_off;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        o_imem_req    = 1'b0;
        o_instr_valid = 1'b0;
        case (r_state)
            S_FETCH: begin
                o_imem_req = ~i_rst;
                if (i_imem_ack) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_instr_valid = 1'b1;
                if (i_instr_ready) begin
                    w_state_nxt = (w_next_pc[1:0] != 2'b00) ? S_ERR : S_FETCH;
                end
            end
            S_ERR: begin
                w_state_nxt = S_ERR;
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC;
            r_instr    <= 32'd0;
            r_addr_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_fill) begin
                r_instr <= i_imem_rdata;
            end
            if (w_accept) begin
                r_pc <= w_next_pc;
                if (w_next_pc[1:0] != 2'b00) begin
                    r_addr_err <= 1'b1;
                end
            end
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = ((r_state == S_FETCH) && !i_imem_ack) ||
                     ((r_state == S_ISSUE) && !i_instr_ready);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_cnt <= 32'd0;
            r_stall_cnt <= 32'd0;
        end else begin
            if (w_accept) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign o_fetch_cnt = r_fetch_cnt;
    assign o_stall_cnt = r_stall_cnt;
`endif

    assign o_imem_addr = r_pc;
    assign o_pc        = r_pc;
    assign o_pc_plus4  = w_pc_plus4;
    assign o_instr     = r_instr;
    assign o_opcode    = r_instr[31:26];
    assign o_addr_err  = r_addr_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios, then randomized traffic against a reference model.
// Counter checks are compiled in when IFU_PERF_CNT_EN is defined.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack = 1'b0;
    logic [31:0] i_imem_rdata = 32'd0;
    logic [31:0] o_instr;
    logic [5:0]  o_opcode;
    logic [31:0] o_pc;
    logic [31:0] o_pc_plus4;
    logic        o_instr_valid;
    logic        i_instr_ready = 1'b0;
    logic        i_branch = 1'b0;
    logic        i_branch_taken = 1'b0;
    logic        i_jmp = 1'b0;
    logic        i_jr = 1'b0;
    logic [31:0] i_jr_target = 32'd0;
    logic        o_addr_err;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] o_fetch_cnt;
    logic [31:0] o_stall_cnt;
`endif

    instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_ack(i_imem_ack), .i_imem_rdata(i_imem_rdata),
        .o_instr(o_instr), .o_opcode(o_opcode), .o_pc(o_pc), .o_pc_plus4(o_pc_plus4),
        .o_instr_valid(o_instr_valid), .i_instr_ready(i_instr_ready),
        .i_branch(i_branch), .i_branch_taken(i_branch_taken),
        .i_jmp(i_jmp), .i_jr(i_jr), .i_jr_target(i_jr_target),
        .o_addr_err(o_addr_err)
`ifdef IFU_PERF_CNT_EN
        , .o_fetch_cnt(o_fetch_cnt), .o_stall_cnt(o_stall_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [31:0] m_pc;
    logic        m_err;
    logic [31:0] m_fetch;
    logic [31:0] m_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Architectural next-PC rule written with plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] ins,
                                             input logic br, input logic tk, input logic jp,
                                             input logic jrr, input logic [31:0] jt);
        logic [31:0] seq;
        int          off;
        seq = pc + 32'd4;
        if (jrr) return jt;
        if (jp) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        if (br && tk) begin
            off = int'($signed(ins[15:0]));
            return seq + 32'(off * 4);
        end
        return seq;
    endfunction

    task automatic chk_cnt(input string tag);
`ifdef IFU_PERF_CNT_EN
        chk({tag, "_fetch_cnt"}, o_fetch_cnt, m_fetch);
        chk({tag, "_stall_cnt"}, o_stall_cnt, m_stall);
`else
        m_fetch = m_fetch;
`endif
    endtask

    task automatic do_reset(input logic ack_during);
        i_rst = 1'b1;
        i_imem_ack = ack_during;
        i_imem_rdata = 32'hDEAD_BEEF;
        i_instr_ready = 1'b0;
        #1;
        chk("req_low_in_rst", 32'(o_imem_req), 32'd0);
        tick();
        i_rst = 1'b0;
        i_imem_ack = 1'b0;
        #1;
        m_pc = RST_PC;
        m_err = 1'b0;
        m_fetch = 32'd0;
        m_stall = 32'd0;
        chk("rst_valid", 32'(o_instr_valid), 32'd0);
        chk("rst_err", 32'(o_addr_err), 32'd0);
        chk("rst_pc", o_pc, RST_PC);
        chk("rst_req", 32'(o_imem_req), 32'd1);
        chk_cnt("rst");
    endtask

    // One full instruction: fetch with ack_wait idle cycles, issue with rdy_wait stalls, then accept.
    task automatic do_instr(input int ack_wait, input int rdy_wait, input logic [31:0] data,
                            input logic br, input logic tk, input logic jp,
                            input logic jrr, input logic [31:0] jt);
        logic [31:0] nx;
        chk("fetch_req", 32'(o_imem_req), 32'd1);
        chk("fetch_addr", o_imem_addr, m_pc);
        chk("fetch_valid", 32'(o_instr_valid), 32'd0);
        for (int k = 0; k < ack_wait; k++) begin
            tick();
            chk("wait_req", 32'(o_imem_req), 32'd1);
            chk("wait_addr", o_imem_addr, m_pc);
        end
        i_imem_ack = 1'b1;
        i_imem_rdata = data;
        tick();
        for (int k = 0; k <= rdy_wait; k++) begin
            chk("issue_valid", 32'(o_instr_valid), 32'd1);
            chk("issue_req", 32'(o_imem_req), 32'd0);
            chk("issue_instr", o_instr, data);
            chk("issue_opcode", 32'(o_opcode), data >> 26);
            chk("issue_pc", o_pc, m_pc);
            chk("issue_pc4", o_pc_plus4, m_pc + 32'd4);
            if (k < rdy_wait) begin
                // stray acks while issuing must not disturb the held instruction
                i_imem_ack = 1'($urandom_range(0, 1));
                i_imem_rdata = $urandom;
                tick();
            end
        end
        i_imem_ack = 1'b0;
        i_instr_ready = 1'b1;
        i_branch = br;
        i_branch_taken = tk;
        i_jmp = jp;
        i_jr = jrr;
        i_jr_target = jt;
        nx = ref_next(m_pc, data, br, tk, jp, jrr, jt);
        tick();
        i_instr_ready = 1'b0;
        i_branch = 1'b0;
        i_branch_taken = 1'b0;
        i_jmp = 1'b0;
        i_jr = 1'b0;
        #1;
        m_pc = nx;
        m_fetch = m_fetch + 32'd1;
        m_stall = m_stall + 32'(ack_wait + rdy_wait);
        if (nx[1:0] != 2'b00) m_err = 1'b1;
        chk("acc_pc", o_pc, m_pc);
        chk("acc_err", 32'(o_addr_err), 32'(m_err));
        chk("acc_req", 32'(o_imem_req), 32'(!m_err));
        chk("acc_valid", 32'(o_instr_valid), 32'd0);
        chk_cnt("acc");
    endtask

    initial begin
        m_pc = RST_PC;
        m_err = 1'b0;
        m_fetch = 32'd0;
        m_stall = 32'd0;

        // sequential fetch, memory answers one cycle after the request
        do_reset(1'b1);
        do_instr(1, 0, 32'h0000_0020, 0, 0, 0, 0, 0);
        do_instr(1, 0, 32'h0000_0021, 0, 0, 0, 0, 0);
        do_instr(1, 0, 32'h0000_0022, 0, 0, 0, 0, 0);
        chk("seq_addr_3", o_imem_addr, 32'h0000_300C);

        // counters: 3 instructions, 1-cycle ack latency, 2 ready stalls
        do_reset(1'b0);
        do_instr(1, 1, 32'h0000_0001, 0, 0, 0, 0, 0);
        do_instr(1, 0, 32'h0000_0002, 0, 0, 0, 0, 0);
        do_instr(1, 1, 32'h0000_0003, 0, 0, 0, 0, 0);
`ifdef IFU_PERF_CNT_EN
        chk("plan_fetch_cnt", o_fetch_cnt, 32'd3);
        chk("plan_stall_cnt", o_stall_cnt, 32'd5);
`endif

        // branches from 0x3000
        do_reset(1'b0);
        do_instr(0, 0, 32'h1000_0003, 1, 1, 0, 0, 0);
        chk("br_taken", o_imem_addr, 32'h0000_3010);
        do_reset(1'b0);
        do_instr(0, 0, 32'h1000_0003, 1, 0, 0, 0, 0);
        chk("br_not_taken", o_imem_addr, 32'h0000_3004);
        do_reset(1'b0);
        do_instr(0, 0, 32'h1000_FFFF, 1, 1, 0, 0, 0);
        chk("br_back", o_imem_addr, 32'h0000_3000);

        // jump from 0x3004, jmp also wins over a simultaneous branch
        do_reset(1'b0);
        do_instr(0, 0, 32'h0000_0000, 0, 0, 0, 0, 0);
        do_instr(0, 0, 32'h0800_0C40, 1, 1, 1, 0, 0);
        chk("jmp_target", o_imem_addr, 32'h0000_3100);

        // jr beats jmp, then a misaligned jr parks the unit
        do_instr(0, 0, 32'h0800_0C40, 0, 0, 1, 1, 32'h0000_3200);
        chk("jr_target", o_imem_addr, 32'h0000_3200);
        do_instr(0, 0, 32'h0000_0000, 0, 0, 0, 1, 32'h0000_3202);
        for (int k = 0; k < 10; k++) begin
            i_imem_ack = 1'b1;
            i_instr_ready = 1'b1;
            tick();
            chk("err_req", 32'(o_imem_req), 32'd0);
            chk("err_valid", 32'(o_instr_valid), 32'd0);
            chk("err_sticky", 32'(o_addr_err), 32'd1);
        end
        i_imem_ack = 1'b0;
        i_instr_ready = 1'b0;
        chk_cnt("err");
        do_reset(1'b0);
        chk("post_err_addr", o_imem_addr, 32'h0000_3000);

        // backpressure on both handshakes
        do_instr(4, 3, 32'hABCD_1234, 0, 0, 0, 0, 0);

        // reset while a request at 0x3008 is outstanding
        do_instr(0, 0, 32'h0000_0000, 0, 0, 0, 0, 0);
        chk("mid_addr", o_imem_addr, 32'h0000_3008);
        tick();
        tick();
        do_reset(1'b0);
        do_instr(0, 0, 32'h1234_5678, 0, 0, 0, 0, 0);

        // randomized traffic with aligned redirects
        do_reset(1'b0);
        for (int n = 0; n < 300; n++) begin
            int          aw;
            int          rw;
            int          sel;
            logic [31:0] d;
            aw  = int'($urandom_range(0, 3));
            rw  = int'($urandom_range(0, 3));
            sel = int'($urandom_range(0, 4));
            d   = $urandom;
            do_instr(aw, rw, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     (sel == 1) || (sel == 3), (sel == 2) || (sel == 3),
                     $urandom & 32'hFFFF_FFFC);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch stage that produces the instruction word (and its opcode field) consumed by the control decoder.
- It also consumes the decoder's branch/jmp outcome to select the next PC.
- It holds the PC, issues requests to instruction memory over a req/ack handshake, and presents one instruction at a time to decode/execute over a valid/ready handshake.
- It redirects on branch, jump or jump-register when that instruction is accepted.

Parameters:
RESET_PC, 32'h0000_3000, PC loaded on reset (must be word aligned)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address, equals pc
imem_ack  input  1  memory returns imem_rdata this cycle
imem_rdata  input  32  instruction word from memory
instr  output  32  latched instruction word
opcode  output  6  instr[31:26], to control decoder
pc  output  32  address of instr
pc_plus4  output  32  pc+4, link value for jal/bltzal/bgezal
instr_valid  output  1  instr/opcode/pc are valid
instr_ready  input  1  downstream accepts instr this cycle
branch  input  1  decoder: instruction is a conditional branch
branch_taken  input  1  execute: branch condition true
jmp  input  1  decoder: j/jal
jr  input  1  decoder: jr/jalr
jr_target  input  32  register value for jr/jalr
addr_err  output  1  sticky misaligned-fetch error

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=FETCH, pc=RESET_PC, instr=0, instr_valid=0, addr_err=0.
  - imem_req is forced 0 in any cycle where rst=1.
- States: FETCH, ISSUE, ERR (2-bit encoded).
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: instr<=imem_rdata, next state ISSUE.
  - Without ack: stay in FETCH with imem_req held high and imem_addr stable.
  - instr_valid=0 in FETCH.
- ISSUE:
  - instr_valid=1, imem_req=0.
  - instr, opcode, pc, pc_plus4 are held stable until accepted.
  - When instr_ready=1: sample branch/branch_taken/jmp/jr/jr_target in the same cycle, load next_pc, go to FETCH.
  - Minimum turnaround with zero-wait memory: 2 cycles per instruction (FETCH+ack, ISSUE+ready).
- next_pc priority, all 32-bit, modulo 2^32, wrap silently:
  - jr: jr_target.
  - else jmp: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - else branch && branch_taken: pc_plus4 + (sign-extend(instr[15:0]) << 2).
  - else: pc_plus4.
- branch=1 with branch_taken=0 selects pc_plus4.
- Simultaneous jmp and branch (illegal decoder output): jmp wins, no error.
- Alignment: if next_pc[1:0] != 0 on acceptance:
  - pc is still loaded with next_pc, addr_err<=1, go to ERR.
  - ERR: imem_req=0, instr_valid=0; remains until rst.
- imem_ack outside FETCH is ignored. imem_ack in the reset cycle is ignored.
- Reset mid-operation:
  - Any pending fetch is abandoned.
  - The first post-reset request is to RESET_PC.
  - A late ack belonging to the old request, arriving in the first post-reset FETCH cycle, is accepted as data for RESET_PC; the memory must not ack stale requests after reset.
- pc_plus4 = pc + 32'd4 (combinational from the pc register). opcode = instr[31:26].

Optional Feature:
IFU_PERF_CNT_EN
- Defined:
  - Adds output ports fetch_cnt[31:0] (increments on each ISSUE acceptance) and stall_cnt[31:0] (increments each cycle in FETCH without imem_ack, or in ISSUE without instr_ready).
  - Both counters reset to 0 on rst and wrap at 2^32.
- Not defined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Sequential fetch:
  - Stimulus: rst 1 cycle; memory acks 1 cycle after req; instr_ready=1, no redirects.
  - Response: imem_addr 0x3000, 0x3004, 0x3008; instr_valid pulses one cycle each; pc_plus4 = 0x3004 for the first instruction.
- Branch at pc=0x3000, instr=0x1000_0003, branch=1:
  - branch_taken=1 -> next imem_addr 0x3010.
  - branch_taken=0 -> 0x3004.
  - instr=0x1000_FFFF taken -> 0x3000.
- Jump at pc=0x3004, instr=0x0800_0C40, jmp=1 -> next imem_addr 0x0000_3100.
- jr priority and alignment:
  - jr=1, jmp=1, jr_target=0x3200 -> next addr 0x3200.
  - jr_target=0x3202 -> addr_err=1, imem_req stays 0 for 10 cycles.
  - rst -> addr_err=0, imem_addr 0x3000.
- Backpressure:
  - instr_ready=0 for 3 cycles in ISSUE -> instr, pc unchanged, imem_req=0.
  - imem_ack withheld 4 cycles in FETCH -> imem_req high and imem_addr stable throughout.
- Reset mid-fetch and counters (IFU_PERF_CNT_EN):
  - rst asserted while imem_req=1 at 0x3008 -> next request 0x3000.
  - With 1-cycle ack latency and 2 ready stalls over 3 instructions: fetch_cnt=3, stall_cnt=5.
